// File: rtl/lcd_nibble_writer.sv
// 4-bit HD44780-style LCD writer: power-on wait, nibble init sequence, fixed
// configuration bytes, then one byte per iData_Ready strobe while in IDLE.
module lcd_nibble_writer #(
  parameter int unsigned POWERUP_WAIT = 750000,
  parameter int unsigned INIT_WAIT1   = 205000,
  parameter int unsigned INIT_WAIT2   = 5000,
  parameter int unsigned CMD_WAIT     = 2000,
  parameter int unsigned CLEAR_WAIT   = 82000,
  parameter int unsigned E_PULSE      = 12,
  parameter int unsigned NIBBLE_GAP   = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iCommand,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG, IDLE, SETUP, PULSE, GAP, DONE_WAIT
  } state_e;

  state_e      state_q;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  byte_q;
  logic        cmd_q;
  logic        lo_q;
  logic        init_q;
  logic        cfg_q;
  logic [1:0]  idx_q;
  logic        rdy_q, e_q, rs_q;
  logic [3:0]  dat_q;
  logic [31:0] len;
  logic        last;
  logic [7:0]  cfg_byte;

  always_comb begin
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;

    case (idx_q)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase

    // Length of the current state in cycles; the last cycle is cnt_q == len-1.
    case (state_q)
      PWR_WAIT:  len = POWERUP_WAIT;
      SETUP:     len = 32'd2;
      PULSE:     len = E_PULSE + 32'd1;
      GAP:       len = NIBBLE_GAP;
      INIT_WAIT: len = (idx_q == 2'd0) ? INIT_WAIT1 :
                       (idx_q == 2'd1) ? INIT_WAIT2 : CMD_WAIT;
      DONE_WAIT: len = (cmd_q && byte_q == 8'h01) ? CLEAR_WAIT : CMD_WAIT;
      default:   len = 32'd1;
    endcase

    last = (32'(cnt_q) + 32'd1) >= len;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      byte_q  <= '0;
      cmd_q   <= 1'b0;
      lo_q    <= 1'b0;
      init_q  <= 1'b0;
      cfg_q   <= 1'b0;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        PWR_WAIT: if (last) begin
          state_q <= INIT_NIB;
          cnt_q   <= '0;
          idx_q   <= '0;
          init_q  <= 1'b1;
        end
        INIT_NIB: begin
          state_q <= SETUP;
          cnt_q   <= '0;
          dat_q   <= (idx_q == 2'd3) ? 4'h2 : 4'h3;
          rs_q    <= 1'b0;
        end
        INIT_WAIT: if (last) begin
          cnt_q <= '0;
          if (idx_q == 2'd3) begin
            state_q <= CFG;
            idx_q   <= '0;
            init_q  <= 1'b0;
            cfg_q   <= 1'b1;
          end else begin
            state_q <= INIT_NIB;
            idx_q   <= idx_q + 2'd1;
          end
        end
        CFG: begin
          state_q <= SETUP;
          cnt_q   <= '0;
          byte_q  <= cfg_byte;
          cmd_q   <= 1'b1;
          lo_q    <= 1'b0;
          dat_q   <= cfg_byte[7:4];
          rs_q    <= 1'b0;
        end
        IDLE: if (iData_Ready) begin
          state_q <= SETUP;
          cnt_q   <= '0;
          byte_q  <= iData;
          cmd_q   <= iCommand;
          lo_q    <= 1'b0;
          dat_q   <= iData[7:4];
          rs_q    <= ~iCommand;
          rdy_q   <= 1'b0;
        end
        SETUP: if (last) begin
          state_q <= PULSE;
          cnt_q   <= '0;
          e_q     <= 1'b1;
        end
        // The final PULSE cycle is the hold cycle: E low, data and RS unchanged.
        PULSE: begin
          if (32'(cnt_q) + 32'd1 >= E_PULSE) e_q <= 1'b0;
          if (last) begin
            cnt_q <= '0;
            dat_q <= '0;
            rs_q  <= 1'b0;
            if (init_q) begin
              state_q <= INIT_WAIT;
            end else if (!lo_q) begin
              state_q <= GAP;
              lo_q    <= 1'b1;
            end else begin
              state_q <= DONE_WAIT;
            end
          end
        end
        GAP: if (last) begin
          state_q <= SETUP;
          cnt_q   <= '0;
          dat_q   <= byte_q[3:0];
          rs_q    <= ~cmd_q;
        end
        DONE_WAIT: if (last) begin
          cnt_q <= '0;
          if (cfg_q && idx_q != 2'd3) begin
            state_q <= CFG;
            idx_q   <= idx_q + 2'd1;
          end else begin
            state_q <= IDLE;
            cfg_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  assign oReadyForData           = rdy_q;
  assign oLCD_Enabled            = e_q;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_Data               = dat_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Scoreboarded bench for lcd_nibble_writer: accepted bytes queue expected E-pulse
// nibbles and ready-low latencies; a monitor checks every pulse and ready return.
module tb_lcd_nibble_writer;

  localparam int unsigned PW  = 20;
  localparam int unsigned IW1 = 10;
  localparam int unsigned IW2 = 5;
  localparam int unsigned CW  = 4;
  localparam int unsigned CLW = 8;
  localparam int unsigned EP  = 3;
  localparam int unsigned NG  = 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] iData = '0;
  logic       iCommand = 1'b0;
  logic       iData_Ready = 1'b0;
  logic       oReadyForData, oLCD_Enabled, oLCD_RegisterSelect;
  logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  logic [4:0] nib_q[$];
  int         lat_q[$];

  lcd_nibble_writer #(
    .POWERUP_WAIT(PW), .INIT_WAIT1(IW1), .INIT_WAIT2(IW2), .CMD_WAIT(CW),
    .CLEAR_WAIT(CLW), .E_PULSE(EP), .NIBBLE_GAP(NG)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iCommand(iCommand),
    .iData_Ready(iData_Ready), .oReadyForData(oReadyForData),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each byte is two RS-tagged nibbles, high first, and the
  // ready-low time is two nibble slots (setup+E+hold), the gap, and the wait.
  function automatic int byte_latency(logic [7:0] b, logic c);
    int w;
    w = (c && b == 8'h01) ? int'(CLW) : int'(CW);
    return 2 * (2 + int'(EP) + 1) + int'(NG) + w;
  endfunction

  function automatic void push_byte(logic [7:0] b, logic c);
    nib_q.push_back({~c, b[7:4]});
    nib_q.push_back({~c, b[3:0]});
  endfunction

  function automatic void push_init();
    logic [3:0] inits[4];
    logic [7:0] cfgs[4];
    inits = '{4'h3, 4'h3, 4'h3, 4'h2};
    cfgs  = '{8'h28, 8'h06, 8'h0C, 8'h01};
    foreach (inits[i]) nib_q.push_back({1'b0, inits[i]});
    foreach (cfgs[i]) push_byte(cfgs[i], 1'b1);
  endfunction

  // Stimulus-side scoreboard push: the DUT accepts on the next rising edge.
  always @(negedge Clock) begin
    if (!Reset && oReadyForData && iData_Ready) begin
      push_byte(iData, iCommand);
      lat_q.push_back(byte_latency(iData, iCommand));
      n_acc++;
    end
  end

  logic [4:0] cap, h1, h2, cur, exp_nib;
  logic       e_prev = 1'b0;
  logic       rdy_prev = 1'b0;
  bit         stable, rdy_seen;
  int         width, low_cnt;

  always @(negedge Clock) begin
    cur = {oLCD_RegisterSelect, oLCD_Data};
    if (Reset) begin
      e_prev = 1'b0; rdy_prev = 1'b0; h1 = '0; h2 = '0;
      width = 0; low_cnt = 0; rdy_seen = 1'b0;
    end else begin
      if (oLCD_Enabled && !e_prev) begin
        cap = cur; width = 1; stable = 1'b1;
        check("setup_2cyc", int'({h1, h2}), int'({cap, cap}));
      end else if (oLCD_Enabled) begin
        width++;
        if (cur != cap) stable = 1'b0;
      end else if (e_prev) begin
        check("e_width", width, int'(EP));
        check("data_stable", int'(stable), 1);
        check("hold_cycle", int'(cur), int'(cap));
        check("pulse_expected", int'(nib_q.size() > 0), 1);
        if (nib_q.size() > 0) begin
          exp_nib = nib_q.pop_front();
          check("nibble", int'(cap), int'(exp_nib));
        end
      end
      h2 = h1; h1 = cur; e_prev = oLCD_Enabled;

      if (!oReadyForData) begin
        low_cnt++;
      end else if (!rdy_prev) begin
        if (rdy_seen) begin
          check("latency_expected", int'(lat_q.size() > 0), 1);
          if (lat_q.size() > 0) check("ready_latency", low_cnt, lat_q.pop_front());
        end
        check("idle_bus", int'({oLCD_Enabled, oLCD_Data, oLCD_ReadWrite,
                                oLCD_StrataFlashControl}), 1);
        rdy_seen = 1'b1;
        low_cnt = 0;
      end
      rdy_prev = oReadyForData;
    end
  end

  task automatic wait_ready(int budget);
    @(negedge Clock);
    for (int i = 0; i < budget && oReadyForData !== 1'b1; i++) @(negedge Clock);
    check("ready_in_time", int'(oReadyForData === 1'b1), 1);
  endtask

  task automatic send(logic [7:0] b, logic c);
    wait_ready(400);
    @(posedge Clock); #1;
    iData = b; iCommand = c; iData_Ready = 1'b1;
    @(posedge Clock); #1;
    iData_Ready = 1'b0; iData = 8'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rises, start;
    logic ep;
    logic [7:0] b;
    logic c;

    push_init();
    @(negedge Clock);
    check("reset_outputs", int'({oReadyForData, oLCD_Enabled, oLCD_RegisterSelect,
                                 oLCD_Data, oLCD_ReadWrite, oLCD_StrataFlashControl}), 1);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    wait_ready(2000);
    check("init_trace_done", nib_q.size(), 0);

    send(8'h41, 1'b0);
    send(8'h01, 1'b1);

    // Busy strobe with 0x55 must be dropped; the pending byte finishes unchanged.
    send(8'h3C, 1'b0);
    repeat (3) @(posedge Clock);
    #1 iData = 8'h55; iData_Ready = 1'b1;
    @(posedge Clock); #1 iData_Ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      b = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      if (i % 5 == 0) begin b = 8'h01; c = 1'b1; end
      send(b, c);
    end

    wait_ready(400);
    start = n_acc;
    @(posedge Clock); #1;
    iData = 8'($urandom); iCommand = 1'($urandom_range(0, 1)); iData_Ready = 1'b1;
    for (int i = 0; i < 400 && n_acc - start < 5; i++) begin
      @(posedge Clock); #1;
      iData = 8'($urandom); iCommand = 1'($urandom_range(0, 1));
    end
    iData_Ready = 1'b0;
    check("held_accepts", n_acc - start, 5);

    // Reset during the lower-nibble pulse.
    send(8'h9A, 1'b0);
    rises = 0; ep = 1'b0;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge Clock);
      if (oLCD_Enabled && !ep) rises++;
      ep = oLCD_Enabled;
    end
    check("lower_pulse_seen", rises, 2);
    @(posedge Clock); #1 Reset = 1'b1;
    nib_q.delete();
    lat_q.delete();
    push_init();
    @(negedge Clock);
    check("e_high_before_reset", int'(oLCD_Enabled), 1);
    @(negedge Clock);
    check("e_drop_on_reset", int'({oLCD_Enabled, oReadyForData, oLCD_RegisterSelect,
                                   oLCD_Data}), 0);
    @(posedge Clock); #1 Reset = 1'b0;
    wait_ready(2000);
    check("reinit_trace_done", nib_q.size(), 0);

    send(8'hA5, 1'b0);
    wait_ready(400);
    repeat (3) @(negedge Clock);
    check("nib_q_empty", nib_q.size(), 0);
    check("lat_q_empty", lat_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
